pio_fifo: RTL and testbench

//  TX/RX data FIFO between the system side and one PIO state machine: TX instance feeds
//  the machine's 32-bit din and is drained by its 'pull' pulse; RX instance is filled by
//  the machine's 'push' pulse with dout. Depth is DEPTH words, or 2*DEPTH when joined.

---
 rtl/pio_fifo_pkg.sv | 12 +
 rtl/pio_fifo.sv | 79 +++++++
 tb/tb_pio_fifo.sv | 137 +++++++++++++
 3 files changed

// File: rtl/pio_fifo_pkg.sv
// pio_fifo_pkg: shared sizing constants and helpers for the PIO data FIFOs
package pio_fifo_pkg;

    localparam int PIO_FIFO_DEPTH = 4;
    localparam int PIO_DATA_W     = 32;

    // Level counter width able to hold 0..2*depth
    function automatic int lvl_w(input int depth);
        return $clog2(2 * depth) + 1;
    endfunction

endpackage

// File: rtl/pio_fifo.sv
// pio_fifo: first-word-fall-through TX/RX FIFO with joinable depth and sticky error flags
module pio_fifo
    import pio_fifo_pkg::*;
#(
    parameter int WIDTH = PIO_DATA_W,
    parameter int DEPTH = PIO_FIFO_DEPTH
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    join_i,
    input  logic                    clear_i,
    input  logic                    clr_flags_i,
    input  logic                    wr_en_i,
    input  logic [WIDTH-1:0]        wr_data_i,
    input  logic                    rd_en_i,
    output logic [WIDTH-1:0]        rd_data_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [lvl_w(DEPTH)-1:0] level_o,
    output logic                    overflow_o,
    output logic                    underflow_o
);

    localparam int N  = 2 * DEPTH;
    localparam int PW = $clog2(N);
    localparam int LW = lvl_w(DEPTH);

    logic [WIDTH-1:0] mem_q [N];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, last;
    logic [LW-1:0]    level_q, level_d, cap;
    logic             join_q, ovf_q, ovf_d, udf_q, udf_d;
    logic             flush, wr_ok, rd_ok;

    // Capacity follows the registered join; pointers wrap at the last usable slot
    always_comb begin
        cap      = join_q ? LW'(N) : LW'(DEPTH);
        last     = PW'(cap - LW'(1));
        full_o   = level_q == cap;
        empty_o  = level_q == '0;
        flush    = clear_i || (join_i != join_q);
        wr_ok    = wr_en_i && (!full_o || rd_en_i) && !flush;
        rd_ok    = rd_en_i && !empty_o && !flush;
        wr_ptr_d = flush ? '0 : !wr_ok ? wr_ptr_q : (wr_ptr_q == last) ? '0 : wr_ptr_q + PW'(1);
        rd_ptr_d = flush ? '0 : !rd_ok ? rd_ptr_q : (rd_ptr_q == last) ? '0 : rd_ptr_q + PW'(1);
        level_d  = flush ? '0 : level_q + LW'(wr_ok) - LW'(rd_ok);
        ovf_d    = (wr_en_i && full_o && !rd_en_i && !flush) || (ovf_q && !clr_flags_i);
        udf_d    = (rd_en_i && empty_o && !flush) || (udf_q && !clr_flags_i);
    end

    // Control state: pointers, level, registered join and sticky flags
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            level_q  <= '0;
            join_q   <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            level_q  <= level_d;
            join_q   <= join_i;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage is deliberately unreset so it can map onto LUT-RAM
    always_ff @(posedge clk_i) begin
        if (wr_ok) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign rd_data_o   = empty_o ? '0 : mem_q[rd_ptr_q];
    assign level_o     = level_q;
    assign overflow_o  = ovf_q;
    assign underflow_o = udf_q;

endmodule

// File: tb/tb_pio_fifo.sv
// tb_pio_fifo: directed scoreboard bench for pio_fifo
module tb_pio_fifo;

    logic        clk_i = 1'b0;
    logic        rst_ni, join_i, clear_i, clr_flags_i, wr_en_i, rd_en_i;
    logic [31:0] wr_data_i, rd_data_o;
    logic        full_o, empty_o, overflow_o, underflow_o;
    logic [3:0]  level_o;

    logic [31:0] q[$];
    int          cap = 4;
    bit          eovf, eudf;
    int          errors = 0;
    int          checks = 0;

    pio_fifo dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .join_i(join_i), .clear_i(clear_i),
        .clr_flags_i(clr_flags_i), .wr_en_i(wr_en_i), .wr_data_i(wr_data_i),
        .rd_en_i(rd_en_i), .rd_data_o(rd_data_o), .full_o(full_o), .empty_o(empty_o),
        .level_o(level_o), .overflow_o(overflow_o), .underflow_o(underflow_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic state(input string tag);
        chk({tag, ".level"}, 32'(level_o), 32'(q.size()));
        chk({tag, ".full"}, 32'(full_o), 32'(q.size() == cap));
        chk({tag, ".empty"}, 32'(empty_o), 32'(q.size() == 0));
        chk({tag, ".rd_data"}, rd_data_o, q.size() == 0 ? 32'h0 : q[0]);
        chk({tag, ".overflow"}, 32'(overflow_o), 32'(eovf));
        chk({tag, ".underflow"}, 32'(underflow_o), 32'(eudf));
    endtask

    // One clock with optional write/read; scoreboard pops the head on an accepted read
    task automatic cyc(input string tag, input logic w, input logic [31:0] d, input logic r);
        bit f, e;
        f = q.size() == cap;
        e = q.size() == 0;
        if (r && !e) begin
            chk({tag, ".pop"}, rd_data_o, q[0]);
            void'(q.pop_front());
        end
        if (w && (!f || r)) q.push_back(d);
        if (w && f && !r) eovf = 1'b1;
        if (r && e) eudf = 1'b1;
        wr_en_i = w; wr_data_i = d; rd_en_i = r;
        @(posedge clk_i); #1;
        wr_en_i = 1'b0; rd_en_i = 1'b0;
        state(tag);
    endtask

    task automatic flush_join(input logic j);
        join_i = j;
        @(posedge clk_i); #1;
        q.delete();
        cap = j ? 8 : 4;
        state("join");
    endtask

    initial begin
        rst_ni = 1'b0; join_i = 1'b0; clear_i = 1'b0; clr_flags_i = 1'b0;
        wr_en_i = 1'b0; rd_en_i = 1'b0; wr_data_i = '0;
        repeat (2) @(posedge clk_i);
        #1 state("reset");
        rst_ni = 1'b1;

        // Fill, then overflow
        for (int i = 1; i <= 4; i++) cyc("fill", 1'b1, 32'hA5A5_0000 + 32'(i), 1'b0);
        cyc("ovf", 1'b1, 32'hDEAD_BEEF, 1'b0);

        // Drain, underflow, clear flags
        for (int i = 0; i < 4; i++) cyc("drain", 1'b0, '0, 1'b1);
        cyc("udf", 1'b0, '0, 1'b1);
        eovf = 1'b0; eudf = 1'b0;
        clr_flags_i = 1'b1; @(posedge clk_i); #1; clr_flags_i = 1'b0;
        state("clrflags");

        // Joined depth and pointer wrap
        flush_join(1'b1);
        for (int i = 1; i <= 8; i++) cyc("jfill", 1'b1, 32'(i), 1'b0);
        cyc("jovf", 1'b1, 32'h99, 1'b0);
        for (int i = 0; i < 8; i++) cyc("jdrain", 1'b0, '0, 1'b1);
        for (int i = 9; i <= 11; i++) cyc("wrapw", 1'b1, 32'(i), 1'b0);
        for (int i = 0; i < 3; i++) cyc("wrapr", 1'b0, '0, 1'b1);

        // Simultaneous read/write while full and while empty
        flush_join(1'b0);
        for (int i = 1; i <= 4; i++) cyc("sfill", 1'b1, 32'(i), 1'b0);
        cyc("fullrw", 1'b1, 32'h55, 1'b1);
        for (int i = 0; i < 4; i++) cyc("sdrain", 1'b0, '0, 1'b1);
        cyc("emptyrw", 1'b1, 32'h77, 1'b1);

        // Set wins over clr_flags on a same-cycle underflow
        cyc("pop77", 1'b0, '0, 1'b1);
        eovf = 1'b0; eudf = 1'b0;
        clr_flags_i = 1'b1;
        cyc("setwins", 1'b0, '0, 1'b1);
        clr_flags_i = 1'b0;

        // Clear overrides a write; flags untouched
        for (int i = 1; i <= 3; i++) cyc("cfill", 1'b1, 32'h100 + 32'(i), 1'b0);
        clear_i = 1'b1; wr_en_i = 1'b1; wr_data_i = 32'hBAD;
        @(posedge clk_i); #1;
        clear_i = 1'b0; wr_en_i = 1'b0;
        q.delete();
        state("clear");

        // Join toggle flushes
        for (int i = 1; i <= 2; i++) cyc("tfill", 1'b1, 32'h200 + 32'(i), 1'b0);
        flush_join(1'b1);
        flush_join(1'b0);

        // Asynchronous reset between edges
        for (int i = 1; i <= 2; i++) cyc("rfill", 1'b1, 32'h300 + 32'(i), 1'b0);
        #2 rst_ni = 1'b0;
        #1;
        q.delete(); eovf = 1'b0; eudf = 1'b0;
        state("areset");
        @(posedge clk_i); #1 rst_ni = 1'b1;
        cyc("resume", 1'b1, 32'hC0DE, 1'b0);
        cyc("resume2", 1'b1, 32'hC0DF, 1'b0);
        cyc("resumepop", 1'b0, '0, 1'b1);
        cyc("resumepop2", 1'b0, '0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
